kronos_mem_arbiter: RTL and testbench
=====================================

KRONOS_MEM_ARBITER -- requirements
Module: kronos_mem_arbiter

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, memory byte-address width.
REQ-002 SHALL have parameter StarveLimit, default 4, consecutive data grants tolerated while instr waits (range 1..15).
REQ-003 SHALL have clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have rst_ni, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have instr_req_i input 1; instr_we_i input 1; instr_addr_i input AddrWidth; instr_wdata_i input 32; instr_strb_i input 32 (bitwise strobe), the instruction requester's request.
REQ-006 SHALL have instr_gnt_o output 1; instr_rvalid_o output 1; instr_rdata_o output 32, the instruction requester's grant and read response.
REQ-007 SHALL have data_* ports identical in name pattern, direction and width to REQ-005/006, the data requester.
REQ-008 SHALL have mem_req_o, mem_we_o output 1; mem_addr_o output AddrWidth; mem_wdata_o, mem_strb_o output 32; mem_rdata_i input 32, one shared single-port SRAM with 1-cycle read latency.

Function
- REQ-009 SHALL grant at most one requester per cycle; gnt outputs are combinational from req inputs and arbiter state.
- REQ-010 SHALL, when both request, grant data (fixed priority), except as modified by REQ-020.
- REQ-011 SHALL drive mem_req_o=1 and forward we/addr/wdata/strb of the granted requester unchanged in the grant cycle; with no grant: mem_req_o=0, other mem outputs 0.
- REQ-012 SHALL track the pending response in an FSM: IDLE, RESP_I, RESP_D; a granted read (we=0) moves to RESP_I/RESP_D; a granted write or no grant moves to IDLE.
- REQ-013 SHALL in RESP_I assert instr_rvalid_o for exactly one cycle, with instr_rdata_o = mem_rdata_i; same for RESP_D on the data side.
- REQ-014 SHALL register each rdata output so it holds its last returned value until that port's next rvalid.
- REQ-015 SHALL accept a new grant in the same cycle a response is returned (back-to-back reads, one per cycle, no bubble).
- REQ-016 SHALL never assert rvalid for writes, nor on both ports in the same cycle.
- REQ-017 SHALL leave a requester waiting (gnt=0) without side effects; req need not stay high.

Reset
- REQ-018 SHALL, while rst_ni=0 at a clock edge, enter IDLE, clear the starvation counter, and force all gnt, rvalid, mem_req_o to 0 and rdata outputs to 0.
- REQ-019 SHALL drop a response pending when reset occurs mid-operation: no rvalid in the cycle after reset release.

Configuration
- REQ-020 SHALL, with macro KRONOS_ARB_STARVE_GUARD_EN defined, count consecutive cycles where data is granted while instr_req_i=1; at count==StarveLimit grant instr instead and clear the counter; the counter clears whenever instr is granted or instr_req_i=0.
- REQ-021 SHALL, without KRONOS_ARB_STARVE_GUARD_EN, contain no counter and use pure fixed priority (instr may starve).

Structure
- REQ-022 SHALL place the response FSM enum (IDLE/RESP_I/RESP_D), owner encoding and the StarveLimit default in shared package kronos_arb_pkg.
- REQ-023 SHALL implement the starvation counter as sub-module kronos_arb_starve_ctr, instantiated only under KRONOS_ARB_STARVE_GUARD_EN.

Verification
- REQ-024 Instr-only read addr 0x80000010, mem_rdata_i=0xDEADBEEF next cycle -> instr_gnt_o=1 same cycle, instr_rvalid_o=1 and instr_rdata_o=0xDEADBEEF one cycle later; data side silent.
- REQ-025 Both read simultaneously -> data granted, instr_gnt_o=0; instr granted next cycle if data_req_i drops; responses arrive in grant order, one per cycle.
- REQ-026 Data write we=1, strb=0x0000FFFF, wdata=0x12345678 -> mem outputs mirror it in grant cycle; no rvalid on either port following.
- REQ-027 Guard enabled, StarveLimit=4, both requesting continuously -> grant pattern D,D,D,D,I repeating; guard disabled -> D forever.
- REQ-028 rst_ni=0 in cycle after a granted read -> no rvalid after release; all outputs 0; first post-reset request served normally.

Source files
------------

// File: rtl/kronos_arb_pkg.sv
// kronos_arb_pkg: shared response-FSM states, owner encoding and starvation default for the memory arbiter
package kronos_arb_pkg;
  localparam int StarveLimitDefault = 4;
  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} resp_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/kronos_arb_starve_ctr.sv
// kronos_arb_starve_ctr: counts consecutive data grants while instr waits; flags when instr must win
module kronos_arb_starve_ctr
  import kronos_arb_pkg::*;
#(
  parameter int StarveLimit = StarveLimitDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic instr_req_i,
  input  logic instr_gnt_i,
  input  logic data_gnt_i,
  output logic starve_o
);
  logic [3:0] cnt_q;
  assign starve_o = cnt_q == 4'(StarveLimit);
  // clear on reset, on an instr grant or when instr stops asking; otherwise count data wins
  always_ff @(posedge clk_i) begin
    if (!rst_ni || instr_gnt_i || !instr_req_i) cnt_q <= '0;
    else if (data_gnt_i) cnt_q <= cnt_q + 4'd1;
  end
endmodule

// File: rtl/kronos_mem_arbiter.sv
// kronos_mem_arbiter: instr/data arbiter onto one single-port SRAM; starvation guard via KRONOS_ARB_STARVE_GUARD_EN
module kronos_mem_arbiter
  import kronos_arb_pkg::*;
#(
  parameter int AddrWidth   = 32,
  parameter int StarveLimit = StarveLimitDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_req_i,
  input  logic                 instr_we_i,
  input  logic [AddrWidth-1:0] instr_addr_i,
  input  logic [31:0]          instr_wdata_i,
  input  logic [31:0]          instr_strb_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [AddrWidth-1:0] data_addr_i,
  input  logic [31:0]          data_wdata_i,
  input  logic [31:0]          data_strb_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [31:0]          mem_strb_o,
  input  logic [31:0]          mem_rdata_i
);
  logic        starve;
  owner_e      own;
  resp_state_e state_q, state_d;
  logic [31:0] instr_rdata_q, data_rdata_q;
`ifdef KRONOS_ARB_STARVE_GUARD_EN
  kronos_arb_starve_ctr #(.StarveLimit(StarveLimit)) u_starve_ctr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .instr_req_i (instr_req_i),
    .instr_gnt_i (instr_gnt_o),
    .data_gnt_i  (data_gnt_o),
    .starve_o    (starve)
  );
`else
  assign starve = 1'b0;
`endif
  assign instr_gnt_o = rst_ni & instr_req_i & (~data_req_i | starve);
  assign data_gnt_o  = rst_ni & data_req_i & ~instr_gnt_o;
  assign mem_req_o   = own != OWN_NONE;
  assign mem_we_o    = own == OWN_I ? instr_we_i    : own == OWN_D ? data_we_i    : 1'b0;
  assign mem_addr_o  = own == OWN_I ? instr_addr_i  : own == OWN_D ? data_addr_i  : '0;
  assign mem_wdata_o = own == OWN_I ? instr_wdata_i : own == OWN_D ? data_wdata_i : '0;
  assign mem_strb_o  = own == OWN_I ? instr_strb_i  : own == OWN_D ? data_strb_i  : '0;
  assign instr_rvalid_o = rst_ni & (state_q == RESP_I);
  assign data_rvalid_o  = rst_ni & (state_q == RESP_D);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : instr_rdata_q;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : data_rdata_q;
  // pick the bus owner and the response expected next cycle (reads only)
  always_comb begin
    own     = instr_gnt_o ? OWN_I : data_gnt_o ? OWN_D : OWN_NONE;
    state_d = (own == OWN_I && !instr_we_i) ? RESP_I :
              (own == OWN_D && !data_we_i)  ? RESP_D : IDLE;
  end
  // response state and held read data per port
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (instr_rvalid_o) instr_rdata_q <= mem_rdata_i;
      if (data_rvalid_o) data_rdata_q <= mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// tb_kronos_mem_arbiter: directed self-checking bench for kronos_mem_arbiter
module tb_kronos_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req = 1'b0, instr_we = 1'b0;
  logic [31:0] instr_addr = '0, instr_wdata = '0, instr_strb = '0;
  logic        instr_gnt, instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req = 1'b0, data_we = 1'b0;
  logic [31:0] data_addr = '0, data_wdata = '0, data_strb = '0;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_strb;
  logic [31:0] mem_rdata = '0;
  int checks = 0;
  int errors = 0;
  kronos_mem_arbiter #(.AddrWidth(32), .StarveLimit(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .instr_req_i    (instr_req),
    .instr_we_i     (instr_we),
    .instr_addr_i   (instr_addr),
    .instr_wdata_i  (instr_wdata),
    .instr_strb_i   (instr_strb),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .data_req_i     (data_req),
    .data_we_i      (data_we),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_strb_i    (data_strb),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_strb_o     (mem_strb),
    .mem_rdata_i    (mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic exp_i, prev_i, prev_d;
    // reset: outputs silent even with a request pending
    instr_req = 1'b1;
    cyc();
    cyc();
    #1;
    chk("rst_instr_gnt", 64'(instr_gnt), 64'd0);
    chk("rst_data_gnt", 64'(data_gnt), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_rvalid", 64'({instr_rvalid, data_rvalid}), 64'd0);
    chk("rst_rdata", {instr_rdata, data_rdata}, 64'd0);
    // instr-only read
    rst_n = 1'b1;
    instr_addr = 32'h8000_0010;
    #1;
    chk("i_rd_gnt", 64'({instr_gnt, data_gnt}), 64'b10);
    chk("i_rd_mem", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h8000_0010});
    cyc();
    instr_req = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("i_rd_rvalid", 64'({instr_rvalid, data_rvalid}), 64'b10);
    chk("i_rd_rdata", 64'(instr_rdata), 64'hDEAD_BEEF);
    chk("i_rd_d_rdata", 64'(data_rdata), 64'd0);
    chk("idle_mem", {mem_req, mem_we, mem_addr}, 64'd0);
    cyc();
    mem_rdata = '0;
    #1;
    chk("i_rd_once", 64'(instr_rvalid), 64'd0);
    chk("i_rd_hold", 64'(instr_rdata), 64'hDEAD_BEEF);
    // simultaneous reads: data first, instr next, responses in order
    instr_req = 1'b1;
    instr_addr = 32'h100;
    data_req = 1'b1;
    data_addr = 32'h200;
    #1;
    chk("both_gnt", 64'({instr_gnt, data_gnt}), 64'b01);
    chk("both_addr", 64'(mem_addr), 64'h200);
    cyc();
    data_req = 1'b0;
    mem_rdata = 32'hAAAA_0001;
    #1;
    chk("b2b_d_resp", {data_rvalid, instr_rvalid, data_rdata}, {1'b1, 1'b0, 32'hAAAA_0001});
    chk("b2b_i_gnt", 64'({instr_gnt, data_gnt}), 64'b10);
    chk("b2b_i_addr", 64'(mem_addr), 64'h100);
    cyc();
    instr_req = 1'b0;
    mem_rdata = 32'hBBBB_0002;
    #1;
    chk("b2b_i_resp", {instr_rvalid, data_rvalid, instr_rdata}, {1'b1, 1'b0, 32'hBBBB_0002});
    chk("b2b_d_hold", 64'(data_rdata), 64'hAAAA_0001);
    cyc();
    mem_rdata = 32'h1111_1111;
    #1;
    chk("b2b_quiet", 64'({instr_rvalid, data_rvalid}), 64'd0);
    chk("b2b_holds", {instr_rdata, data_rdata}, {32'hBBBB_0002, 32'hAAAA_0001});
    // data write mirrored onto the memory port, no response
    data_req = 1'b1;
    data_we = 1'b1;
    data_addr = 32'h0000_0040;
    data_wdata = 32'h1234_5678;
    data_strb = 32'h0000_FFFF;
    #1;
    chk("wr_gnt", 64'({instr_gnt, data_gnt}), 64'b01);
    chk("wr_ctl", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 32'h40});
    chk("wr_data", {mem_wdata, mem_strb}, {32'h1234_5678, 32'h0000_FFFF});
    cyc();
    data_req = 1'b0;
    data_we = 1'b0;
    #1;
    chk("wr_no_rvalid", 64'({instr_rvalid, data_rvalid}), 64'd0);
    cyc();
    // continuous contention: guard gives D,D,D,D,I; without it data wins forever
    instr_req = 1'b1;
    data_req = 1'b1;
    prev_i = 1'b0;
    prev_d = 1'b0;
    for (int k = 0; k < 10; k++) begin
`ifdef KRONOS_ARB_STARVE_GUARD_EN
      exp_i = (k % 5) == 4;
`else
      exp_i = 1'b0;
`endif
      #1;
      chk($sformatf("starve_gnt_%0d", k), 64'({instr_gnt, data_gnt}), 64'({exp_i, ~exp_i}));
      chk($sformatf("starve_rv_%0d", k), 64'({instr_rvalid, data_rvalid}), 64'({prev_i, prev_d}));
      prev_i = exp_i;
      prev_d = ~exp_i;
      cyc();
    end
    instr_req = 1'b0;
    data_req = 1'b0;
    cyc();
    cyc();
    // reset while a read response is pending
    instr_req = 1'b1;
    instr_addr = 32'h0000_0080;
    #1;
    chk("rr_gnt", 64'(instr_gnt), 64'd1);
    cyc();
    instr_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rr_rvalid_in_rst", 64'(instr_rvalid), 64'd0);
    cyc();
    rst_n = 1'b1;
    mem_rdata = 32'h9999_9999;
    #1;
    chk("rr_no_rvalid", 64'({instr_rvalid, data_rvalid}), 64'd0);
    chk("rr_rdata_clr", {instr_rdata, data_rdata}, 64'd0);
    chk("rr_mem_idle", {mem_req, mem_addr}, 64'd0);
    cyc();
    instr_req = 1'b1;
    instr_addr = 32'h0000_00C0;
    #1;
    chk("rr_post_gnt", {instr_gnt, mem_req, mem_addr}, {1'b1, 1'b1, 32'hC0});
    cyc();
    instr_req = 1'b0;
    mem_rdata = 32'h5555_AAAA;
    #1;
    chk("rr_post_resp", {instr_rvalid, instr_rdata}, {1'b1, 32'h5555_AAAA});
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
